// File: rtl/riscv_axi_rd_arb.sv
// Round-robin arbiter that shares one AXI4 read port between instruction fetch (I) and data (D) masters.
// One burst is in flight at a time, and a grant holds until the last R beat of that burst.
module riscv_axi_rd_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter bit FIRST_I = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              axi_i_arvalid_i,
    input  logic [ADDR_W-1:0] axi_i_araddr_i,
    input  logic [ID_W-1:0]   axi_i_arid_i,
    input  logic [7:0]        axi_i_arlen_i,
    input  logic [1:0]        axi_i_arburst_i,
    output logic              axi_i_arready_o,
    output logic              axi_i_rvalid_o,
    output logic [DATA_W-1:0] axi_i_rdata_o,
    output logic [1:0]        axi_i_rresp_o,
    output logic [ID_W-1:0]   axi_i_rid_o,
    output logic              axi_i_rlast_o,
    input  logic              axi_i_rready_i,
    input  logic              axi_d_arvalid_i,
    input  logic [ADDR_W-1:0] axi_d_araddr_i,
    input  logic [ID_W-1:0]   axi_d_arid_i,
    input  logic [7:0]        axi_d_arlen_i,
    input  logic [1:0]        axi_d_arburst_i,
    output logic              axi_d_arready_o,
    output logic              axi_d_rvalid_o,
    output logic [DATA_W-1:0] axi_d_rdata_o,
    output logic [1:0]        axi_d_rresp_o,
    output logic [ID_W-1:0]   axi_d_rid_o,
    output logic              axi_d_rlast_o,
    input  logic              axi_d_rready_i,
    output logic              axi_m_arvalid_o,
    output logic [ADDR_W-1:0] axi_m_araddr_o,
    output logic [ID_W-1:0]   axi_m_arid_o,
    output logic [7:0]        axi_m_arlen_o,
    output logic [1:0]        axi_m_arburst_o,
    input  logic              axi_m_arready_i,
    input  logic              axi_m_rvalid_i,
    input  logic              axi_m_rlast_i,
    input  logic [DATA_W-1:0] axi_m_rdata_i,
    input  logic [1:0]        axi_m_rresp_i,
    input  logic [ID_W-1:0]   axi_m_rid_i,
    output logic              axi_m_rready_o,
    output logic              owner_o,
    output logic              proto_err_o
);

    // state | meaning
    // IDLE  | no burst in flight; arbitrate and accept one AR
    // ADDR  | latched AR presented downstream, waiting for arready
    // DATA  | R beats routed to owner until the rlast handshake
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state, state_nxt;
    logic              owner;
    logic              req_any;
    logic              grant_d;
    logic              owner_rready;
    logic              r_hs;
    logic [7:0]        beat_cnt;
    logic [7:0]        arlen_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [ID_W-1:0]   arid_q;
    logic [1:0]        arburst_q;
    logic              proto_err_q;

    assign req_any      = axi_i_arvalid_i | axi_d_arvalid_i;
    // On a tie the master that did not win last time gets the port.
    assign grant_d      = (axi_i_arvalid_i & axi_d_arvalid_i) ? ~owner : axi_d_arvalid_i;
    assign owner_rready = owner ? axi_d_rready_i : axi_i_rready_i;
    assign r_hs         = (state == DATA) & axi_m_rvalid_i & owner_rready;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = ADDR;
            ADDR:    if (axi_m_arready_i) state_nxt = DATA;
            DATA:    if (r_hs && axi_m_rlast_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        axi_i_arready_o = 1'b0;
        axi_d_arready_o = 1'b0;
        axi_m_arvalid_o = 1'b0;
        axi_m_rready_o  = 1'b0;
        axi_i_rvalid_o  = 1'b0;
        axi_i_rdata_o   = '0;
        axi_i_rresp_o   = '0;
        axi_i_rid_o     = '0;
        axi_i_rlast_o   = 1'b0;
        axi_d_rvalid_o  = 1'b0;
        axi_d_rdata_o   = '0;
        axi_d_rresp_o   = '0;
        axi_d_rid_o     = '0;
        axi_d_rlast_o   = 1'b0;
        case (state)
            IDLE: begin
                axi_i_arready_o = axi_i_arvalid_i & ~grant_d;
                axi_d_arready_o = axi_d_arvalid_i & grant_d;
            end
            ADDR: axi_m_arvalid_o = 1'b1;
            DATA: begin
                axi_m_rready_o = owner_rready;
                if (owner) begin
                    axi_d_rvalid_o = axi_m_rvalid_i;
                    axi_d_rdata_o  = axi_m_rdata_i;
                    axi_d_rresp_o  = axi_m_rresp_i;
                    axi_d_rid_o    = axi_m_rid_i;
                    axi_d_rlast_o  = axi_m_rlast_i;
                end else begin
                    axi_i_rvalid_o = axi_m_rvalid_i;
                    axi_i_rdata_o  = axi_m_rdata_i;
                    axi_i_rresp_o  = axi_m_rresp_i;
                    axi_i_rid_o    = axi_m_rid_i;
                    axi_i_rlast_o  = axi_m_rlast_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner       <= FIRST_I;
            araddr_q    <= '0;
            arid_q      <= '0;
            arlen_q     <= '0;
            arburst_q   <= '0;
            beat_cnt    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= 1'b0;
            if (state == IDLE && req_any) begin
                owner     <= grant_d;
                araddr_q  <= grant_d ? axi_d_araddr_i  : axi_i_araddr_i;
                arid_q    <= grant_d ? axi_d_arid_i    : axi_i_arid_i;
                arlen_q   <= grant_d ? axi_d_arlen_i   : axi_i_arlen_i;
                arburst_q <= grant_d ? axi_d_arburst_i : axi_i_arburst_i;
            end
            if (state == ADDR && axi_m_arready_i) beat_cnt <= '0;
            if (r_hs) begin
                // Count saturates so an overlong burst cannot wrap back onto arlen.
                if (beat_cnt != 8'hff) beat_cnt <= beat_cnt + 8'd1;
                proto_err_q <= (axi_m_rlast_i && beat_cnt != arlen_q) ||
                               (!axi_m_rlast_i && beat_cnt == arlen_q);
            end
        end
    end

    assign owner_o         = owner;
    assign proto_err_o     = proto_err_q;
    assign axi_m_araddr_o  = araddr_q;
    assign axi_m_arid_o    = arid_q;
    assign axi_m_arlen_o   = arlen_q;
    assign axi_m_arburst_o = arburst_q;

endmodule

// File: tb/tb_riscv_axi_rd_arb.sv
// Bench for riscv_axi_rd_arb: random I/D masters and a random slave, checked every cycle
// against a transaction-level model of the arbitration rules plus a per-master data scoreboard.
module tb_riscv_axi_rd_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mv [2];
    logic [31:0] ma [2];
    logic [3:0]  mi [2];
    logic [7:0]  ml [2];
    logic [1:0]  mb [2];
    logic        rr [2];

    logic        i_arready, i_rvalid, i_rlast, d_arready, d_rvalid, d_rlast;
    logic [31:0] i_rdata, d_rdata;
    logic [1:0]  i_rresp, d_rresp;
    logic [3:0]  i_rid, d_rid;

    logic        arr [2];
    logic        rv  [2];
    logic        rl  [2];
    logic [31:0] rd  [2];
    logic [1:0]  rs  [2];
    logic [3:0]  ri  [2];

    logic        m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0, m_rready;
    logic [31:0] m_araddr, m_rdata = '0;
    logic [3:0]  m_arid, m_rid = '0;
    logic [7:0]  m_arlen;
    logic [1:0]  m_arburst, m_rresp = '0;
    logic        owner, perr;

    riscv_axi_rd_arb #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .FIRST_I(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .axi_i_arvalid_i(mv[0]), .axi_i_araddr_i(ma[0]), .axi_i_arid_i(mi[0]),
        .axi_i_arlen_i(ml[0]), .axi_i_arburst_i(mb[0]), .axi_i_arready_o(i_arready),
        .axi_i_rvalid_o(i_rvalid), .axi_i_rdata_o(i_rdata), .axi_i_rresp_o(i_rresp),
        .axi_i_rid_o(i_rid), .axi_i_rlast_o(i_rlast), .axi_i_rready_i(rr[0]),
        .axi_d_arvalid_i(mv[1]), .axi_d_araddr_i(ma[1]), .axi_d_arid_i(mi[1]),
        .axi_d_arlen_i(ml[1]), .axi_d_arburst_i(mb[1]), .axi_d_arready_o(d_arready),
        .axi_d_rvalid_o(d_rvalid), .axi_d_rdata_o(d_rdata), .axi_d_rresp_o(d_rresp),
        .axi_d_rid_o(d_rid), .axi_d_rlast_o(d_rlast), .axi_d_rready_i(rr[1]),
        .axi_m_arvalid_o(m_arvalid), .axi_m_araddr_o(m_araddr), .axi_m_arid_o(m_arid),
        .axi_m_arlen_o(m_arlen), .axi_m_arburst_o(m_arburst), .axi_m_arready_i(m_arready),
        .axi_m_rvalid_i(m_rvalid), .axi_m_rlast_i(m_rlast), .axi_m_rdata_i(m_rdata),
        .axi_m_rresp_i(m_rresp), .axi_m_rid_i(m_rid), .axi_m_rready_o(m_rready),
        .owner_o(owner), .proto_err_o(perr)
    );

    always_comb begin
        arr[0] = i_arready; arr[1] = d_arready;
        rv[0]  = i_rvalid;  rv[1]  = d_rvalid;
        rl[0]  = i_rlast;   rl[1]  = d_rlast;
        rd[0]  = i_rdata;   rd[1]  = d_rdata;
        rs[0]  = i_rresp;   rs[1]  = d_rresp;
        ri[0]  = i_rid;     ri[1]  = d_rid;
    end

    int tests = 0, fails = 0;

    // Model of the arbiter: phase 0 = free, 1 = address pending downstream, 2 = beats flowing.
    int          mph = 0;
    logic        mown = 1'b1;
    logic [31:0] maddr = '0;
    logic [3:0]  mid_q = '0;
    logic [7:0]  mlen = '0;
    logic [1:0]  mbur = '0;
    int          mcnt = 0;
    logic        merr = 1'b0;

    int          s_ph = 0, s_beat = 0, lastmode = 0;
    logic [31:0] s_addr = '0;
    logic [7:0]  s_len = '0;
    logic [3:0]  s_id = '0;

    logic hs_ar [2];
    logic hs_r  [2];
    logic m_ar_hs = 1'b0, m_r_hs = 1'b0;

    logic [31:0] pa [2];
    logic [7:0]  pl [2];
    int rxb [2];
    int beats_rx [2];
    int rv_seen [2];
    int errpulses = 0, cyc = 0, cyc_ar_i = -1, cyc_marv = -1;
    int grants [$];

    int p_req [2];
    int p_rr = 100, p_arr = 100, p_rv = 100, max_len = 4, rr_hold = 0;

    function automatic logic [31:0] sdata(input logic [31:0] a, input int b);
        return (a ^ 32'hA5C3_0000) + 32'(b) * 32'h0101_0101;
    endfunction

    function automatic int last_beat(input int len);
        return (lastmode == 1) ? 0 : (lastmode == 2) ? len + 1 : len;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mph = 0; mown = 1'b1; maddr = '0; mid_q = '0; mlen = '0; mbur = '0;
        mcnt = 0; merr = 1'b0;
        for (int k = 0; k < 2; k++) rxb[k] = 0;
    endtask

    // Compare process, called at every falling edge.
    task automatic observe();
        logic win, own;
        logic [39:0] er;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            hs_ar[k] = arr[k] && mv[k];
            hs_r[k]  = rv[k] && rr[k];
        end
        m_ar_hs = m_arvalid && m_arready;
        m_r_hs  = m_rvalid && m_rready;
        if (rst) begin
            model_reset();
            return;
        end
        win = (mv[0] && mv[1]) ? !mown : !mv[0];
        for (int k = 0; k < 2; k++)
            chk($sformatf("arready%0d", k), arr[k], mph == 0 && mv[k] && int'(win) == k);
        chk("m_arvalid", m_arvalid, mph == 1);
        chk("m_ar_payload", {m_araddr, m_arid, m_arlen, m_arburst}, {maddr, mid_q, mlen, mbur});
        chk("m_rready", m_rready, mph == 2 ? rr[mown] : 1'b0);
        for (int k = 0; k < 2; k++) begin
            own = (mph == 2) && int'(mown) == k;
            er = own ? {m_rvalid, m_rlast, m_rresp, m_rid, m_rdata} : 40'h0;
            chk($sformatf("r_route%0d", k), {rv[k], rl[k], rs[k], ri[k], rd[k]}, er);
            if (rv[k]) rv_seen[k]++;
        end
        chk("owner", owner, mown);
        chk("proto_err", perr, merr);
        if (perr) errpulses++;
        if (m_arvalid && cyc_marv < 0) cyc_marv = cyc;

        for (int k = 0; k < 2; k++) begin
            if (hs_r[k]) begin
                chk($sformatf("r_data%0d", k), rd[k], sdata(pa[k], rxb[k]));
                rxb[k]++;
                beats_rx[k]++;
                if (rl[k]) chk($sformatf("r_beats%0d", k), rxb[k], last_beat(int'(pl[k])) + 1);
            end
            if (hs_ar[k]) begin
                grants.push_back(k);
                pa[k] = ma[k]; pl[k] = ml[k]; rxb[k] = 0;
                if (k == 0 && cyc_ar_i < 0) cyc_ar_i = cyc;
            end
        end

        merr = 1'b0;
        case (mph)
            0: if (mv[0] || mv[1]) begin
                maddr = ma[win]; mid_q = mi[win]; mlen = ml[win]; mbur = mb[win];
                mown = win; mph = 1;
            end
            1: if (m_arready) begin mph = 2; mcnt = 0; end
            default: if (m_rvalid && rr[mown]) begin
                merr = (m_rlast && mcnt != int'(mlen)) || (!m_rlast && mcnt == int'(mlen));
                if (mcnt < 255) mcnt++;
                if (m_rlast) mph = 0;
            end
        endcase
    endtask

    // Masters and slave react to the handshakes seen at the previous falling edge.
    task automatic drive();
        if (rst) begin
            for (int k = 0; k < 2; k++) begin mv[k] = 1'b0; rr[k] = 1'b0; end
            m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; s_ph = 0;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (hs_ar[k]) mv[k] = 1'b0;
            if (!mv[k] && int'($urandom_range(99)) < p_req[k]) begin
                mv[k] = 1'b1;
                ma[k] = $urandom & 32'hFFFF_FFFC;
                mi[k] = 4'($urandom_range(15));
                ml[k] = 8'($urandom_range(max_len));
                mb[k] = 2'b01;
            end
            rr[k] = (rr_hold > 0) ? 1'b0 : int'($urandom_range(99)) < p_rr;
        end
        if (rr_hold > 0) rr_hold--;
        if (m_ar_hs) begin
            s_ph = 1; s_addr = m_araddr; s_len = m_arlen; s_id = m_arid; s_beat = 0;
        end
        if (m_r_hs) begin
            if (m_rlast) s_ph = 0;
            s_beat++;
            m_rvalid = 1'b0;
        end
        if (!m_rvalid) begin
            if (s_ph == 1 && int'($urandom_range(99)) < p_rv) begin
                m_rvalid = 1'b1;
                m_rdata  = sdata(s_addr, s_beat);
                m_rlast  = (s_beat == last_beat(int'(s_len)));
                m_rid    = s_id;
                m_rresp  = 2'($urandom_range(3));
            end else begin
                m_rdata = $urandom; m_rlast = 1'($urandom_range(1));
                m_rid = 4'($urandom_range(15)); m_rresp = 2'($urandom_range(3));
            end
        end
        m_arready = (s_ph == 0) && int'($urandom_range(99)) < p_arr;
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    task automatic req_i(input logic [31:0] a, input logic [7:0] len);
        mv[0] = 1'b1; ma[0] = a; mi[0] = 4'h2; ml[0] = len; mb[0] = 2'b01;
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_owner"}, owner, 1'b1);
        chk({nm, "_valids"}, {m_arvalid, i_rvalid, d_rvalid, m_rready, perr}, 5'b0);
    endtask

    task automatic wait_beats(input int k, input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (beats_rx[k] < target && n < budget) begin step(); n++; end
        chk({nm, "_timeout"}, beats_rx[k] >= target, 1'b1);
    endtask

    task automatic drain(input string nm);
        int n;
        p_req[0] = 0; p_req[1] = 0;
        n = 0;
        while ((mph != 0 || mv[0] || mv[1]) && n < 400) begin step(); n++; end
        chk({nm, "_drain"}, mph == 0 && !mv[0] && !mv[1], 1'b1);
    endtask

    initial begin
        int b0, b1, e0, v1;
        for (int k = 0; k < 2; k++) begin
            mv[k] = 1'b0; ma[k] = '0; mi[k] = '0; ml[k] = '0; mb[k] = '0; rr[k] = 1'b0;
            hs_ar[k] = 1'b0; hs_r[k] = 1'b0; pa[k] = '0; pl[k] = '0;
            rxb[k] = 0; beats_rx[k] = 0; rv_seen[k] = 0; p_req[k] = 0;
        end

        // Reset state, then a lone I burst of four beats at 0x100.
        do_reset(3);
        check_reset_state("reset");
        cyc_ar_i = -1; cyc_marv = -1;
        b0 = beats_rx[0]; b1 = beats_rx[1]; e0 = errpulses; v1 = rv_seen[1];
        req_i(32'h100, 8'd3);
        wait_beats(0, b0 + 4, 40, "t1");
        for (int i = 0; i < 3; i++) step();
        chk("t1_i_beats", beats_rx[0] - b0, 4);
        chk("t1_d_beats", beats_rx[1] - b1, 0);
        chk("t1_d_rvalid", rv_seen[1] - v1, 0);
        chk("t1_no_err", errpulses - e0, 0);
        chk("t1_arvalid_lag", cyc_marv - cyc_ar_i, 1);

        // Simultaneous requests from reset, then continuous ties: grants must alternate.
        do_reset(2);
        grants.delete();
        p_req[0] = 100; p_req[1] = 100; max_len = 2;
        for (int n = 0; n < 300 && grants.size() < 4; n++) step();
        chk("t3_grant_count", grants.size() >= 4, 1'b1);
        for (int g = 0; g < 4 && g < grants.size(); g++)
            chk($sformatf("t3_grant%0d", g), grants[g], g % 2);
        drain("t3");

        // Owner stalls rready for five cycles mid-burst.
        do_reset(2);
        b0 = beats_rx[0];
        req_i(32'h2000, 8'd3);
        wait_beats(0, b0 + 1, 40, "t4a");
        rr_hold = 5;
        wait_beats(0, b0 + 4, 60, "t4b");
        for (int i = 0; i < 3; i++) step();
        chk("t4_beats", beats_rx[0] - b0, 4);

        // Slave ends an arlen=1 burst on beat 0.
        do_reset(2);
        lastmode = 1;
        b0 = beats_rx[0]; e0 = errpulses;
        req_i(32'h3000, 8'd1);
        for (int i = 0; i < 20; i++) step();
        chk("t5_err_pulses", errpulses - e0, 1);
        chk("t5_beats", beats_rx[0] - b0, 1);
        chk("t5_idle", m_arvalid, 1'b0);
        lastmode = 0;

        // Reset while beat 2 of a burst is in flight.
        do_reset(2);
        b0 = beats_rx[0];
        req_i(32'h4000, 8'd5);
        wait_beats(0, b0 + 2, 40, "t6");
        do_reset(1);
        check_reset_state("t6");

        // Randomised segments with varied backpressure, burst lengths and rlast behaviour.
        do_reset(2);
        for (int seg = 0; seg < 40; seg++) begin
            p_req[0] = $urandom_range(100); p_req[1] = $urandom_range(100);
            p_rr = 20 + $urandom_range(80); p_arr = 20 + $urandom_range(80);
            p_rv = 20 + $urandom_range(80); max_len = $urandom_range(7);
            lastmode = ($urandom_range(5) == 0) ? 1 + $urandom_range(1) : 0;
            for (int i = 0; i < 100; i++) step();
            drain("rand");
            for (int i = 0; i < 3; i++) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
